// File: rtl/collision_pkg.sv
// Shared constants, FSM encoding and helpers for the collision monitor.
package collision_pkg;

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned INV_W   = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PLAY   = 3'd1;
  localparam logic [2:0] HIT    = 3'd2;
  localparam logic [2:0] INVULN = 3'd3;
  localparam logic [2:0] OVER   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StPlay   = PLAY,
    StHit    = HIT,
    StInvuln = INVULN,
    StOver   = OVER
  } state_e;

  function automatic int unsigned ovl_max_f(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned OVL_W_DEFAULT = 12;
  localparam int unsigned OVL_MAX       = ovl_max_f(OVL_W_DEFAULT);

endpackage

// File: rtl/overlap_counter.sv
// Saturating per-frame overlap counter with frame reload and hit threshold compare.
// COLLISION_DEBUG_EN adds a latched frame count and a peak tracker.
module overlap_counter
  import collision_pkg::*;
#(
  parameter int unsigned OVL_W      = 12,
  parameter int unsigned HIT_THRESH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             frame_i,
  input  logic             ovl_i,
  output logic             eval_o,
  output logic             frame_hit_o,
  output logic [OVL_W-1:0] peak_o
);

  localparam logic [OVL_W-1:0] CntMax = OVL_W'(ovl_max_f(OVL_W));
  localparam logic [OVL_W-1:0] Thresh = OVL_W'(HIT_THRESH);

  logic [OVL_W-1:0] cnt_d, cnt_q;
  logic             eval_d, eval_q;
  logic             hit_d, hit_q;

  always_comb begin
    cnt_d  = cnt_q;
    eval_d = 1'b0;
    hit_d  = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (frame_i) begin
      // A pixel coincident with the frame pulse already belongs to the new frame.
      cnt_d  = OVL_W'(ovl_i);
      eval_d = 1'b1;
      hit_d  = (cnt_q >= Thresh);
    end else if (ovl_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + OVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      eval_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      eval_q <= eval_d;
      hit_q  <= hit_d;
    end
  end

  assign eval_o      = eval_q;
  assign frame_hit_o = hit_q;

`ifdef COLLISION_DEBUG_EN
  logic [OVL_W-1:0] frame_cnt_d, frame_cnt_q;
  logic [OVL_W-1:0] peak_d, peak_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    peak_d      = peak_q;
    if (clear_i) begin
      frame_cnt_d = '0;
      peak_d      = '0;
    end else begin
      if (frame_i) begin
        frame_cnt_d = cnt_q;
      end
      if (eval_q && (frame_cnt_q > peak_q)) begin
        peak_d = frame_cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= '0;
      peak_q      <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      peak_q      <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

endmodule

// File: rtl/collision_monitor.sv
// Per-frame collision decision plus lives / invulnerability / game-over FSM.
// Define COLLISION_DEBUG_EN to drive peak_overlap with the per-game peak frame count.
module collision_monitor
  import collision_pkg::*;
#(
  parameter int unsigned CIDXW         = 3,
  parameter int unsigned OVL_W         = 12,
  parameter int unsigned HIT_THRESH    = 16,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               pix_en,
  input  logic               bright,
  input  logic               frame,
  input  logic               game_active,
  input  logic [CIDXW:0]     char_pix,
  input  logic [CIDXW:0]     obstacle_pix,
  output logic               fail_pulse,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               game_over,
  output logic [OVL_W-1:0]   peak_overlap
);

  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);
  localparam logic [INV_W-1:0]   InvInit   = INV_W'(INVULN_FRAMES);

  logic ovl_event;
  logic frame_eval;
  logic frame_hit;

  assign ovl_event = pix_en & bright & (|char_pix) & (|obstacle_pix);

  overlap_counter #(
    .OVL_W      (OVL_W),
    .HIT_THRESH (HIT_THRESH)
  ) u_overlap_counter (
    .clk_i       (Clk),
    .rst_ni      (Reset_n),
    .clear_i     (~game_active),
    .frame_i     (frame),
    .ovl_i       (ovl_event),
    .eval_o      (frame_eval),
    .frame_hit_o (frame_hit),
    .peak_o      (peak_overlap)
  );

  state_e             state_q;
  logic [LIVES_W-1:0] lives_q;
  logic [INV_W-1:0]   inv_cnt_q;
  logic               fail_q;
  logic               invuln_q;
  logic               over_q;
  // Set on every entry to PLAY: the next frame decision covers a frame that
  // was only partly counted (or counted while immune), so it is discarded.
  logic               skip_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      lives_q   <= '0;
      inv_cnt_q <= '0;
      fail_q    <= 1'b0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
      skip_q    <= 1'b0;
    end else if (!game_active) begin
      state_q   <= StIdle;
      lives_q   <= '0;
      inv_cnt_q <= '0;
      fail_q    <= 1'b0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          lives_q <= LivesInit;
          skip_q  <= 1'b1;
          state_q <= StPlay;
        end
        StPlay: begin
          if (frame_eval) begin
            skip_q <= 1'b0;
            if (frame_hit && !skip_q) begin
              fail_q  <= 1'b1;
              lives_q <= lives_q - LIVES_W'(1);
              state_q <= StHit;
            end
          end
        end
        StHit: begin
          if (lives_q == '0) begin
            over_q  <= 1'b1;
            state_q <= StOver;
          end else begin
            inv_cnt_q <= InvInit;
            invuln_q  <= 1'b1;
            state_q   <= StInvuln;
          end
        end
        StInvuln: begin
          if (frame) begin
            if (inv_cnt_q <= INV_W'(1)) begin
              inv_cnt_q <= '0;
              invuln_q  <= 1'b0;
              skip_q    <= 1'b1;
              state_q   <= StPlay;
            end else begin
              inv_cnt_q <= inv_cnt_q - INV_W'(1);
            end
          end
        end
        StOver: begin
          state_q <= StOver;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign fail_pulse = fail_q;
  assign lives      = lives_q;
  assign invuln     = invuln_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Randomized bench for collision_monitor against a frame-level game model.
module tb_collision_monitor;

  localparam int HitThresh = 16;
  localparam int LivesInit = 3;
  localparam int InvFrames = 60;
  localparam int OvlMax    = 4095;

  logic        Clk;
  logic        Reset_n;
  logic        pix_en;
  logic        bright;
  logic        frame;
  logic        game_active;
  logic [3:0]  char_pix;
  logic [3:0]  obstacle_pix;
  logic        fail_pulse;
  logic [2:0]  lives;
  logic        invuln;
  logic        game_over;
  logic [11:0] peak_overlap;

  collision_monitor u_dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pix_en       (pix_en),
    .bright       (bright),
    .frame        (frame),
    .game_active  (game_active),
    .char_pix     (char_pix),
    .obstacle_pix (obstacle_pix),
    .fail_pulse   (fail_pulse),
    .lives        (lives),
    .invuln       (invuln),
    .game_over    (game_over),
    .peak_overlap (peak_overlap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int quiet = 0;
  bit ga_r  = 1'b0;

  // Game model kept at frame granularity; pulse timing via known latency.
  bit m_active = 1'b0;
  bit m_skip   = 1'b0;
  bit m_over   = 1'b0;
  int m_cnt    = 0;
  int m_lives  = 0;
  int m_inv    = 0;
  int m_peak   = 0;
  int hit_cyc  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_peak();
`ifdef COLLISION_DEBUG_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    m_active = 1'b0;
    m_skip   = 1'b0;
    m_over   = 1'b0;
    m_cnt    = 0;
    m_lives  = 0;
    m_inv    = 0;
    m_peak   = 0;
  endtask

  task automatic model_step(input bit fr, input bit ov);
    bit ev;
    int c;
    ev = 1'b0;
    if (!ga_r) begin
      if (m_active) ev = 1'b1;
      model_clear();
      if (hit_cyc >= cyc) hit_cyc = -1;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_lives  = LivesInit;
        m_skip   = 1'b1;
        ev       = 1'b1;
      end
      if (fr) begin
        ev    = 1'b1;
        c     = m_cnt;
        m_cnt = ov ? 1 : 0;
        if (c > m_peak) m_peak = c;
        if (m_over) begin
          m_over = 1'b1;
        end else if (m_inv > 0) begin
          m_inv--;
        end else if (m_skip) begin
          m_skip = 1'b0;
        end else if (c >= HitThresh) begin
          hit_cyc = cyc + 1;
          m_lives--;
          if (m_lives == 0) m_over = 1'b1;
          else m_inv = InvFrames;
        end
      end else if (ov && (m_cnt < OvlMax)) begin
        m_cnt++;
      end
    end
    quiet = ev ? 0 : quiet + 1;
  endtask

  task automatic check_status(input string pfx);
    check({pfx, "_lives"},  32'(lives),        32'(m_lives));
    check({pfx, "_invuln"}, 32'(invuln),       32'(m_inv > 0));
    check({pfx, "_over"},   32'(game_over),    32'(m_over));
    check({pfx, "_peak"},   32'(peak_overlap), 32'(exp_peak()));
  endtask

  task automatic drive_pixels(input bit ov);
    if (ov) begin
      pix_en       = 1'b1;
      bright       = 1'b1;
      char_pix     = 4'($urandom_range(1, 15));
      obstacle_pix = 4'($urandom_range(1, 15));
    end else begin
      pix_en       = 1'($urandom);
      bright       = 1'($urandom);
      char_pix     = 4'($urandom);
      obstacle_pix = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       pix_en = 1'b0;
        1:       bright = 1'b0;
        2:       char_pix = 4'd0;
        default: obstacle_pix = 4'd0;
      endcase
    end
  endtask

  task automatic tick(input bit fr, input bit ov);
    frame       = fr;
    game_active = ga_r;
    drive_pixels(ov);
    @(posedge Clk);
    cyc++;
    model_step(fr, ov);
    #1;
    check("fail_pulse", 32'(fail_pulse), 32'(cyc == hit_cyc));
    if (quiet == 4) check_status("st");
    else if (!m_active && quiet == 0) check_status("drop");
  endtask

  task automatic run_frame(input int n, input bit coin);
    int len;
    int r;
    len = n + 20 + int'($urandom_range(0, 15));
    r   = n;
    for (int s = len; s > 0; s--) begin
      bit ov;
      ov = (r > 0) && (int'($urandom_range(0, s - 1)) < r);
      if (ov) r--;
      tick(1'b0, ov);
    end
    tick(1'b1, coin);
  endtask

  task automatic do_reset(input int n);
    Reset_n = 1'b0;
    #1;
    model_clear();
    hit_cyc = -1;
    quiet   = 0;
    check("rst_fail", 32'(fail_pulse), 32'd0);
    check_status("rst");
    for (int i = 0; i < n; i++) begin
      frame       = 1'($urandom);
      game_active = 1'($urandom);
      drive_pixels(1'($urandom));
      @(posedge Clk);
      #1;
      check("rst_hold_fail", 32'(fail_pulse), 32'd0);
      check_status("rst_hold");
    end
    frame   = 1'b0;
    Reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset_n      = 1'b0;
    frame        = 1'b0;
    game_active  = 1'b0;
    pix_en       = 1'b0;
    bright       = 1'b0;
    char_pix     = 4'd0;
    obstacle_pix = 4'd0;

    do_reset(3);
    repeat (6) tick(1'b0, 1'b0);

    // Threshold: partial first frame is discarded, then 15 vs 16 overlaps.
    ga_r = 1'b1;
    repeat (5) tick(1'b0, 1'($urandom));
    run_frame(20, 1'b0);
    run_frame(15, 1'b0);
    run_frame(16, 1'b0);

    // Immunity window; the final pulse carries a coincident overlap.
    repeat (InvFrames - 1) run_frame(100, 1'b0);
    run_frame(100, 1'b1);
    run_frame(15, 1'b0);

    repeat (InvFrames - 1) run_frame(int'($urandom_range(0, 40)), 1'b0);
    run_frame(0, 1'b0);

    // Saturating frame makes the third hit; game over then holds.
    run_frame(5000, 1'b0);
    repeat (3) run_frame(50, 1'b0);
    ga_r = 1'b0;
    tick(1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0);

    // game_active drops in the cycle frame_hit is presented.
    ga_r = 1'b1;
    repeat (4) tick(1'b0, 1'b0);
    run_frame(0, 1'b0);
    run_frame(30, 1'b0);
    ga_r = 1'b0;
    tick(1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b0);

    // Peak tracking over frames of 20, 50 and 30 overlaps.
    ga_r = 1'b1;
    repeat (4) tick(1'b0, 1'b0);
    run_frame(0, 1'b0);
    run_frame(20, 1'b0);
    run_frame(50, 1'b0);
    run_frame(30, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    check("peak_dbg", 32'(peak_overlap), 32'(exp_peak()));

    // Asynchronous reset in the middle of a frame while the game stays active.
    repeat (7) tick(1'b0, 1'b1);
    do_reset(2);
    repeat (5) tick(1'b0, 1'b0);
    run_frame(3, 1'b0);
    run_frame(16, 1'b0);

    // Random counts around the threshold, random coincident overlaps.
    ga_r = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    ga_r = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    run_frame(0, 1'b0);
    repeat (6) run_frame(int'($urandom_range(10, 22)), 1'($urandom));
    repeat (10) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/collision_monitor.md
Name: collision_monitor

Overview:
- Sits directly downstream of the pixel-merge stage in the game top level.
- Consumes the per-pixel character and obstacle colour indices, then accumulates the overlap pixels seen in each frame.
- Decides once per frame whether a hit occurred and runs the lives / invulnerability / game-over state machine.
- Replaces the raw per-pixel FAIL_signal with a clean one-cycle fail_pulse, lives count and game_over flag for core and score logic.

Parameters:
- CIDXW, 3, colour-index width; pixel inputs are CIDXW+1 bits wide.
- OVL_W, 12, overlap counter width; the counter saturates at 2^OVL_W-1.
- HIT_THRESH, 16, minimum overlap pixels in one frame that count as a hit (1..2^OVL_W-1).
- LIVES_INIT, 3, lives loaded at game start (1..7).
- INVULN_FRAMES, 60, frames of immunity after a non-fatal hit (1..255).

Ports:
- Clk  in  1  system clock (ClkPort domain).
- Reset_n  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel-rate enable (one Clk cycle per pixel).
- bright  in  1  active-video qualifier.
- frame  in  1  one-cycle pulse at start of frame (first Clk after vc wraps to 0).
- game_active  in  1  high while core is in a playing state.
- char_pix  in  CIDXW+1  character pixel index; 0 means transparent.
- obstacle_pix  in  CIDXW+1  obstacle pixel index; 0 means transparent.
- fail_pulse  out  1  one-cycle pulse per accepted hit.
- lives  out  3  remaining lives.
- invuln  out  1  high during the invulnerability window.
- game_over  out  1  high in the OVER state.
- peak_overlap  out  OVL_W  debug output (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Overlap event: pix_en & bright & (char_pix!=0) & (obstacle_pix!=0).
- Overlap counter:
  - Increments by 1 per overlap event and saturates, never wraps.
  - On a frame pulse, frame_cnt latches the count and the counter reloads to 0, or to 1 if an overlap event occurs in the same cycle. That pixel belongs to the new frame.
- frame_hit is registered one cycle after frame, and equals (frame_cnt >= HIT_THRESH). Hit decision latency is frame+1.
- FSM states: IDLE, PLAY, HIT, INVULN, OVER.
  - IDLE: lives=0. When game_active=1, load lives=LIVES_INIT and go to PLAY. The first frame_hit after entry is ignored; the counter was cleared on entry.
  - PLAY: on frame_hit, go to HIT.
  - HIT: lasts exactly one cycle.
    - fail_pulse=1; lives decrements.
    - If lives was 1: lives=0 and go to OVER.
    - Otherwise: load inv_cnt=INVULN_FRAMES and go to INVULN.
  - INVULN: invuln=1; frame_hit is ignored. Each frame decrements inv_cnt. When it reaches 0 at a frame pulse, go to PLAY; the overlap counter is freshly cleared by that same pulse.
  - OVER: game_over=1; lives hold at 0. Stays here until game_active=0.
  - From any state, game_active=0 returns to IDLE next cycle and clears lives, invuln, game_over and counters. This takes priority over every other transition.
- A frame_hit arriving in the same cycle that game_active drops is discarded.
- Asserting Reset_n low mid-frame clears everything asynchronously. The first frame after release is counted from whatever pixel position it starts at; this is acceptable.
- Only one fail_pulse is produced per frame, regardless of overlap count.

Optional Feature:
- Macro COLLISION_DEBUG_EN.
- Defined: peak_overlap holds the maximum frame_cnt observed since the last IDLE entry, updated at frame+1 and saturating.
- Undefined: peak_overlap is tied to 0 and the peak register is not synthesised.
- The port exists in both builds.

Decomposition:
- Package collision_pkg holds:
  - the FSM state encoding (3-bit localparams IDLE=0, PLAY=1, HIT=2, INVULN=3, OVER=4);
  - LIVES_W=3 and INV_W=8;
  - helper constant OVL_MAX.
- One sub-module, overlap_counter, holds the saturating per-frame counter with frame reload, plus the threshold compare producing frame_hit.
- The FSM and lives logic stay in collision_monitor.

Test Plan:
- Reset: Reset_n low, any inputs -> all outputs 0, state IDLE; release with game_active=0 -> outputs stay 0.
- Threshold: game_active=1, HIT_THRESH=16, 15 overlap pixels in a frame -> no fail_pulse; 16 pixels -> fail_pulse exactly one cycle at frame+2, lives 3->2, invuln=1.
- Invulnerability: after a hit, 100 overlaps per frame for 60 frames -> no fail_pulse; invuln drops at the 60th frame pulse; next frame with 16 overlaps -> lives 2->1.
- Game over: three accepted hits -> lives=0, game_over=1, further overlaps produce no fail_pulse; game_active=0 -> IDLE next cycle, game_over=0.
- Boundaries:
  - Overlap coincident with the frame pulse -> new frame count starts at 1.
  - 5000 overlaps with OVL_W=12 -> frame_cnt=4095.
  - game_active dropping in the same cycle as frame_hit -> no fail_pulse.
- Debug: with COLLISION_DEBUG_EN, frames of 20, 50 and 30 overlaps -> peak_overlap=50; without the macro -> peak_overlap=0 throughout.
